// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential shift-and-add multiplier for W-bit operands.
// Signed operands are multiplied as magnitudes and the sign is applied
// once to the final 2W-bit product. The result is held in DONE until the
// consumer acks or DONE_HOLD cycles elapse.
//
// Every register resets to zero and IDLE is encoded as zero, so a
// zero-initialised power-up state is identical to the reset state.
module mult_seq_param #(
  parameter int W         = 32,
  parameter int DONE_HOLD = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           ack,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int         PW   = 2 * W;
  localparam logic [7:0] HOLD = 8'(DONE_HOLD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   p_q, p_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [W-1:0]    mplier_shr;
  logic            neg_q, neg_d;
  logic [7:0]      cnt_q, cnt_d;

  // Magnitude of an operand; in signed mode the most negative value maps
  // to 2^(W-1), which still fits as a W-bit unsigned number.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x,
                                             input logic         sm);
    if (sm && x[W-1]) begin
      return (~x) + W'(1);
    end
    return x;
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [PW-1:0] negate_pw(input logic [PW-1:0] x);
    return (~x) + PW'(1);
  endfunction

  // Status outputs decode the state register only.
  assign busy = (state_q == CHECK) || (state_q == ADD) || (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign p    = p_q;

  // Next-state and datapath update for the shift-and-add sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    mplier_shr = mplier_q >> 1;

    case (state_q)
      IDLE: begin
        if (init) begin
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, magnitude(a, signed_mode)};
          mplier_d = magnitude(b, signed_mode);
          neg_d    = signed_mode & (a[W-1] ^ b[W-1]);
          state_d  = CHECK;
        end
      end

      CHECK: begin
        state_d = mplier_q[0] ? ADD : SHIFT;
      end

      ADD: begin
        // acc never exceeds |a|*|b| < 2^(2W), so no carry out is lost.
        acc_d   = acc_q + mcand_q;
        state_d = SHIFT;
      end

      SHIFT: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        if (mplier_shr == '0) begin
          p_d     = neg_q ? negate_pw(acc_q) : acc_q;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          state_d = CHECK;
        end
      end

      DONE: begin
        // cnt_d is the number of DONE cycles completed after this edge.
        cnt_d = cnt_q + 8'd1;
        if (ack || (cnt_d == HOLD)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and hold-counter registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/mult_seq_param.md
MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 SHALL have parameter W, default 32: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter DONE_HOLD, default 10: number of cycles done is held when no ack arrives, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port init, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with init.
REQ-007 SHALL have port a, input, W bits: multiplicand, sampled with init.
REQ-008 SHALL have port b, input, W bits: multiplier, sampled with init.
REQ-009 SHALL have port ack, input, 1 bit: consumer has read p; ends DONE early.
REQ-010 SHALL have port busy, output, 1 bit: high in CHECK, ADD and SHIFT.
REQ-011 SHALL have port done, output, 1 bit: high only in DONE.
REQ-012 SHALL have port p, output, 2W bits: product register.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, CHECK, ADD, SHIFT and DONE; busy and done SHALL be decoded from the state register only.
REQ-014 IDLE, with init=1 at an edge: SHALL load the acc (2W) register with 0; load mcand (2W) with zero-extended |a|; load mplier (W) with |b|; set neg = signed_mode & (a[W-1] ^ b[W-1]); go to CHECK. With init=0, SHALL stay in IDLE.
REQ-015 Magnitudes: with signed_mode=0, |x| = x. With signed_mode=1, |x| = two's-complement negation of x when x[W-1]=1, treated as W-bit unsigned, so -2^(W-1) maps to 2^(W-1).
REQ-016 CHECK: SHALL go to ADD when mplier[0]=1, otherwise to SHIFT.
REQ-017 ADD: SHALL perform acc <= acc + mcand (2W-bit, no overflow possible) and then go to SHIFT.
REQ-018 SHIFT: SHALL perform mcand <= mcand << 1 and mplier <= mplier >> 1. SHALL go to DONE if the shifted mplier == 0, else to CHECK.
REQ-019 On the SHIFT-to-DONE edge: SHALL load p <= neg ? (2's-complement negate of acc) : acc. Apart from this edge, p SHALL change only on reset.
REQ-020 Latency: let m = index of the highest set bit of |b| (m=0 when |b|=0) and k = number of set bits in |b| at positions 0..m. done SHALL first be high in the cycle 2(m+1)+k+1 after the init-sampling edge.
REQ-021 DONE: SHALL count cycles from 1. SHALL return to IDLE after DONE_HOLD cycles, or on the first edge with ack=1, whichever comes first. The counter SHALL clear on entering DONE.
REQ-022 init SHALL be ignored outside IDLE. Changes on a, b and signed_mode after the sampling edge SHALL have no effect on the operation in progress.
REQ-023 ack outside DONE SHALL be ignored.
REQ-024 p SHALL keep its value through IDLE until the next SHIFT-to-DONE edge.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter IDLE regardless of state (including mid-operation and DONE) and set p=0, acc=0, mcand=0, mplier=0, neg=0 and the DONE counter to 0; busy=0 and done=0 SHALL follow from the next cycle.
REQ-026 rst SHALL take priority over init and ack.
REQ-027 Power-up (simulation initial) values SHALL equal the reset values.

Verification
REQ-028 The bench SHALL cover: W=32, unsigned, a=3, b=5, init pulse -> done rises 9 cycles after the sampling edge, p=15, done held 10 cycles with ack=0, then IDLE.
REQ-029 The bench SHALL cover: W=32, signed, a=-7 (0xFFFFFFF9), b=6 -> p=0xFFFF_FFFF_FFFF_FFD6 (-42), with ack pulsed in the 2nd DONE cycle -> IDLE on that edge.
REQ-030 The bench SHALL cover: W=8, signed, a=b=0x80 -> p=0x4000. W=8, unsigned, a=b=0xFF -> p=0xFE01, with latency 2*8+8+1=25.
REQ-031 The bench SHALL cover: b=0, a=0x1234 -> done in cycle 3 and p=0. A second init while busy is ignored, with no restart.
REQ-032 The bench SHALL cover: rst asserted in the 4th busy cycle -> next cycle IDLE, busy=0, done=0, p=0. A new init afterwards yields a correct product.
REQ-033 The bench SHALL cover: a randomized run of 1000 operands per mode, W=16, checked against a reference product and the REQ-020 latency.
